// File: rtl/regfile_write_queue.sv
// regfile_write_queue: two-producer writeback FIFO feeding the register file write port.
// Optional pending-write bypass lookups are built when WQ_BYPASS_EN is defined.
module regfile_write_queue #(
    parameter int N     = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   alu_valid,
    input  logic [4:0]             alu_reg,
    input  logic [N-1:0]           alu_data,
    output logic                   alu_ready,
    input  logic                   mem_valid,
    input  logic [4:0]             mem_reg,
    input  logic [N-1:0]           mem_data,
    output logic                   mem_ready,
    output logic                   RegWrite,
    output logic [4:0]             WriteRegister,
    output logic [N-1:0]           WriteData,
    output logic [$clog2(DEPTH):0] count,
    input  logic [4:0]             ReadRegister1,
    input  logic [4:0]             ReadRegister2,
    output logic                   hit1,
    output logic                   hit2,
    output logic [N-1:0]           hit_data1,
    output logic [N-1:0]           hit_data2
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [4:0]    reg_q [DEPTH];
    logic [N-1:0]  dat_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          rw_q;
    logic [4:0]    wr_q;
    logic [N-1:0]  wd_q;

    logic          mem_acc, alu_acc;
    logic          mem_push, alu_push;
    logic          pop;
    logic [PW-1:0] alu_slot;

    // Readiness is judged on pre-pop occupancy; mem gets the last free slot.
    assign mem_ready = (count_q < CW'(DEPTH));
    assign alu_ready = (count_q <= CW'(DEPTH - 2)) || (mem_ready && !mem_valid);

    assign mem_acc  = mem_valid && mem_ready;
    assign alu_acc  = alu_valid && alu_ready;
    assign mem_push = mem_acc && (mem_reg != 5'd0);
    assign alu_push = alu_acc && (alu_reg != 5'd0);
    assign pop      = (count_q != '0);

    // The load is the older instruction, so it takes the first tail slot.
    assign alu_slot = tail_q + PW'(mem_push);
    assign tail_d   = tail_q + PW'(mem_push) + PW'(alu_push);
    assign head_d   = head_q + PW'(pop);
    assign count_d  = count_q + CW'(mem_push) + CW'(alu_push) - CW'(pop);

    // Entry storage; contents are only meaningful below count_q.
    always_ff @(posedge clk) begin
        if (mem_push) begin
            reg_q[tail_q] <= mem_reg;
            dat_q[tail_q] <= mem_data;
        end
        if (alu_push) begin
            reg_q[alu_slot] <= alu_reg;
            dat_q[alu_slot] <= alu_data;
        end
    end

    // Pointers, occupancy and the registered write-port stage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            rw_q    <= 1'b0;
            wr_q    <= '0;
            wd_q    <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            rw_q    <= pop;
            if (pop) begin
                wr_q <= reg_q[head_q];
                wd_q <= dat_q[head_q];
            end
        end
    end

    assign RegWrite      = rw_q;
    assign WriteRegister = wr_q;
    assign WriteData     = wd_q;
    assign count         = count_q;

`ifdef WQ_BYPASS_EN
    logic [PW-1:0] idx;

    // Youngest match wins: output stage first, then FIFO oldest-to-youngest overrides.
    always_comb begin
        hit1      = 1'b0;
        hit2      = 1'b0;
        hit_data1 = '0;
        hit_data2 = '0;
        idx       = head_q;
        if (rw_q && (wr_q == ReadRegister1) && (ReadRegister1 != 5'd0)) begin
            hit1      = 1'b1;
            hit_data1 = wd_q;
        end
        if (rw_q && (wr_q == ReadRegister2) && (ReadRegister2 != 5'd0)) begin
            hit2      = 1'b1;
            hit_data2 = wd_q;
        end
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if ((CW'(i) < count_q) && (reg_q[idx] == ReadRegister1)
                && (ReadRegister1 != 5'd0)) begin
                hit1      = 1'b1;
                hit_data1 = dat_q[idx];
            end
            if ((CW'(i) < count_q) && (reg_q[idx] == ReadRegister2)
                && (ReadRegister2 != 5'd0)) begin
                hit2      = 1'b1;
                hit_data2 = dat_q[idx];
            end
        end
    end
`else
    logic unused_rd;

    assign unused_rd = ^{ReadRegister1, ReadRegister2};
    assign hit1      = 1'b0;
    assign hit2      = 1'b0;
    assign hit_data1 = '0;
    assign hit_data2 = '0;
`endif

endmodule

// File: tb/tb_regfile_write_queue.sv
// tb_regfile_write_queue: directed and randomized checks of regfile_write_queue
// against a queue-based reference model.
module tb_regfile_write_queue;
    localparam int N     = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          alu_valid, mem_valid;
    logic [4:0]    alu_reg, mem_reg;
    logic [N-1:0]  alu_data, mem_data;
    logic          alu_ready, mem_ready;
    logic          RegWrite;
    logic [4:0]    WriteRegister;
    logic [N-1:0]  WriteData;
    logic [CW-1:0] count;
    logic [4:0]    ReadRegister1, ReadRegister2;
    logic          hit1, hit2;
    logic [N-1:0]  hit_data1, hit_data2;

    always #5 clk = ~clk;

    regfile_write_queue #(.N(N), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_reg(mem_reg), .mem_data(mem_data), .mem_ready(mem_ready),
        .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
        .count(count),
        .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
        .hit1(hit1), .hit2(hit2), .hit_data1(hit_data1), .hit_data2(hit_data2)
    );

    typedef struct {
        logic [4:0]   r;
        logic [N-1:0] d;
    } ent_t;

    ent_t         mq[$];
    logic         exp_rw;
    logic [4:0]   exp_wr;
    logic [N-1:0] exp_wd;
    bit           last_ma, last_aa;
    int           vec  = 0;
    int           errs = 0;

    task automatic model_reset();
        mq.delete();
        exp_rw = 1'b0;
        exp_wr = '0;
        exp_wd = '0;
    endtask

    // Advance one clock edge and update the reference model with what the edge does.
    task automatic tick();
        int   fr;
        bit   ma, aa;
        ent_t e;
        fr = DEPTH - mq.size();
        ma = mem_valid && (fr >= 1);
        aa = alu_valid && ((fr >= 2) || (fr >= 1 && !mem_valid));
        @(posedge clk);
        if (mq.size() > 0) begin
            e      = mq.pop_front();
            exp_rw = 1'b1;
            exp_wr = e.r;
            exp_wd = e.d;
        end else begin
            exp_rw = 1'b0;
        end
        if (ma && mem_reg != 5'd0) mq.push_back('{r: mem_reg, d: mem_data});
        if (aa && alu_reg != 5'd0) mq.push_back('{r: alu_reg, d: alu_data});
        last_ma = ma;
        last_aa = aa;
        #1;
    endtask

    // Youngest pending value for a register, oldest (output stage) first.
    function automatic logic [N:0] byp_model(input logic [4:0] rr);
        logic         h;
        logic [N-1:0] d;
        h = 1'b0;
        d = '0;
        if (rr != 5'd0) begin
            if (exp_rw && exp_wr == rr) begin
                h = 1'b1;
                d = exp_wd;
            end
            foreach (mq[i]) begin
                if (mq[i].r == rr) begin
                    h = 1'b1;
                    d = mq[i].d;
                end
            end
        end
`ifndef WQ_BYPASS_EN
        h = 1'b0;
        d = '0;
`endif
        return {h, d};
    endfunction

    task automatic idle_inputs();
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        alu_reg   = '0;
        mem_reg   = '0;
        alu_data  = '0;
        mem_data  = '0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        ReadRegister1 = '0;
        ReadRegister2 = '0;
        repeat (3) @(posedge clk);
        #1;
        vec++; if (RegWrite !== 1'b0) begin errs++; $display("FAIL reset_rw: got %0h want 0", RegWrite); end
        vec++; if (count !== '0) begin errs++; $display("FAIL reset_count: got %0d want 0", count); end
        vec++; if ({WriteRegister, WriteData} !== '0) begin errs++; $display("FAIL reset_addr_data: got %0h/%0h want 0/0", WriteRegister, WriteData); end
        vec++; if ({hit1, hit2, hit_data1, hit_data2} !== '0) begin errs++; $display("FAIL reset_hits: got %0b%0b %0h %0h want zeros", hit1, hit2, hit_data1, hit_data2); end
        rst = 1'b1;
        model_reset();
        tick();
        tick();
        vec++; if (RegWrite !== 1'b0) begin errs++; $display("FAIL idle_rw: got %0h want 0", RegWrite); end
        vec++; if (count !== '0) begin errs++; $display("FAIL idle_count: got %0d want 0", count); end
        vec++; if ({alu_ready, mem_ready} !== 2'b11) begin errs++; $display("FAIL idle_ready: got %0b%0b want 11", alu_ready, mem_ready); end
    endtask

    task automatic test_single();
        alu_valid = 1'b1;
        alu_reg   = 5'd5;
        alu_data  = 32'hDEADBEEF;
        #1;
        vec++; if (alu_ready !== 1'b1) begin errs++; $display("FAIL single_ready: got %0b want 1", alu_ready); end
        tick();
        alu_valid = 1'b0;
        vec++; if (count !== CW'(1)) begin errs++; $display("FAIL single_count: got %0d want 1", count); end
        vec++; if (RegWrite !== 1'b0) begin errs++; $display("FAIL single_rw_early: got %0b want 0", RegWrite); end
        tick();
        vec++; if ({RegWrite, WriteRegister, WriteData} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin errs++; $display("FAIL single_write: got %0b/%0d/%0h want 1/5/deadbeef", RegWrite, WriteRegister, WriteData); end
        tick();
        vec++; if ({RegWrite, WriteData} !== {1'b0, 32'hDEADBEEF}) begin errs++; $display("FAIL single_end: got %0b/%0h want 0/deadbeef", RegWrite, WriteData); end
    endtask

    task automatic test_dual();
        mem_valid = 1'b1; mem_reg = 5'd3; mem_data = 32'h11;
        alu_valid = 1'b1; alu_reg = 5'd3; alu_data = 32'h22;
        #1;
        vec++; if ({alu_ready, mem_ready} !== 2'b11) begin errs++; $display("FAIL dual_ready: got %0b%0b want 11", alu_ready, mem_ready); end
        tick();
        idle_inputs();
        vec++; if (count !== CW'(2)) begin errs++; $display("FAIL dual_count: got %0d want 2", count); end
        tick();
        vec++; if ({RegWrite, WriteRegister, WriteData} !== {1'b1, 5'd3, 32'h11}) begin errs++; $display("FAIL dual_first: got %0b/%0d/%0h want 1/3/11", RegWrite, WriteRegister, WriteData); end
        tick();
        vec++; if ({RegWrite, WriteRegister, WriteData} !== {1'b1, 5'd3, 32'h22}) begin errs++; $display("FAIL dual_second: got %0b/%0d/%0h want 1/3/22", RegWrite, WriteRegister, WriteData); end
        tick();
        vec++; if (RegWrite !== 1'b0) begin errs++; $display("FAIL dual_end: got %0b want 0", RegWrite); end
    endtask

    task automatic test_backpressure();
        logic [4:0]   er[6] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6};
        logic [N-1:0] ed[6] = '{32'hA1, 32'hA2, 32'hB3, 32'hB4, 32'hC5, 32'hC6};
        int idx = 0;
        for (int c = 0; c < 10; c++) begin
            case (c)
                0: begin
                    mem_valid = 1'b1; mem_reg = 5'd1; mem_data = 32'hA1;
                    alu_valid = 1'b1; alu_reg = 5'd2; alu_data = 32'hA2;
                end
                1: begin
                    mem_reg = 5'd3; mem_data = 32'hB3;
                    alu_reg = 5'd4; alu_data = 32'hB4;
                end
                2: begin
                    mem_reg = 5'd5; mem_data = 32'hC5;
                    alu_reg = 5'd6; alu_data = 32'hC6;
                end
                3: mem_valid = 1'b0;
                default: idle_inputs();
            endcase
            #1;
            if (c == 1) begin
                vec++; if ({count, alu_ready, mem_ready} !== {CW'(2), 2'b11}) begin errs++; $display("FAIL bp_c1: got count=%0d rdy=%0b%0b want 2 11", count, alu_ready, mem_ready); end
            end
            if (c == 2) begin
                vec++; if ({count, alu_ready, mem_ready} !== {CW'(3), 2'b01}) begin errs++; $display("FAIL bp_c2: got count=%0d rdy=%0b%0b want 3 01", count, alu_ready, mem_ready); end
            end
            if (c == 3) begin
                vec++; if ({count, alu_ready} !== {CW'(3), 1'b1}) begin errs++; $display("FAIL bp_c3: got count=%0d alu_rdy=%0b want 3 1", count, alu_ready); end
            end
            tick();
            if (RegWrite === 1'b1) begin
                vec++;
                if (idx >= 6) begin
                    errs++; $display("FAIL bp_extra_write: got reg %0d want no write", WriteRegister);
                end else if ({WriteRegister, WriteData} !== {er[idx], ed[idx]}) begin
                    errs++; $display("FAIL bp_order: got %0d/%0h want %0d/%0h", WriteRegister, WriteData, er[idx], ed[idx]);
                end
                idx++;
            end
        end
        vec++; if (idx != 6 || count !== '0) begin errs++; $display("FAIL bp_total: got %0d writes count=%0d want 6 writes count=0", idx, count); end
    endtask

    task automatic test_reg0();
        alu_valid = 1'b1; alu_reg = 5'd0; alu_data = 32'hFFFFFFFF;
        ReadRegister1 = 5'd0;
        #1;
        vec++; if ({alu_ready, hit1} !== 2'b10) begin errs++; $display("FAIL r0_ready_hit: got %0b%0b want 10", alu_ready, hit1); end
        tick();
        idle_inputs();
        vec++; if (count !== '0) begin errs++; $display("FAIL r0_count: got %0d want 0", count); end
        tick();
        vec++; if (RegWrite !== 1'b0) begin errs++; $display("FAIL r0_rw: got %0b want 0", RegWrite); end
        tick();
        vec++; if (RegWrite !== 1'b0) begin errs++; $display("FAIL r0_rw2: got %0b want 0", RegWrite); end
    endtask

    task automatic test_bypass();
        logic [N:0] want;
        ReadRegister1 = 5'd7;
        ReadRegister2 = 5'd9;
        mem_valid = 1'b1; mem_reg = 5'd7; mem_data = 32'hA;
        alu_valid = 1'b1; alu_reg = 5'd7; alu_data = 32'hB;
        #1;
        tick();
        idle_inputs();
        #1;
`ifdef WQ_BYPASS_EN
        want = {1'b1, 32'hB};
`else
        want = '0;
`endif
        vec++; if ({hit1, hit_data1} !== want) begin errs++; $display("FAIL byp_two: got %0b/%0h want %0b/%0h", hit1, hit_data1, want[N], want[N-1:0]); end
        vec++; if ({hit2, hit_data2} !== '0) begin errs++; $display("FAIL byp_miss2: got %0b/%0h want 0/0", hit2, hit_data2); end
        tick();
        #1;
        vec++; if ({hit1, hit_data1} !== want) begin errs++; $display("FAIL byp_one: got %0b/%0h want %0b/%0h", hit1, hit_data1, want[N], want[N-1:0]); end
        tick();
        #1;
        vec++; if ({hit1, hit_data1} !== want) begin errs++; $display("FAIL byp_outstage: got %0b/%0h want %0b/%0h", hit1, hit_data1, want[N], want[N-1:0]); end
        tick();
        #1;
        vec++; if ({hit1, hit_data1} !== '0) begin errs++; $display("FAIL byp_drained: got %0b/%0h want 0/0", hit1, hit_data1); end
    endtask

    task automatic test_random();
        logic [N:0] w1, w2;
        mem_valid = 1'b0;
        alu_valid = 1'b0;
        last_ma   = 1'b1;
        last_aa   = 1'b1;
        for (int c = 0; c < 400; c++) begin
            if (!mem_valid || last_ma) begin
                mem_valid = ($urandom_range(0, 3) != 0);
                mem_reg   = 5'($urandom_range(0, 7));
                mem_data  = $urandom;
            end
            if (!alu_valid || last_aa) begin
                alu_valid = ($urandom_range(0, 3) != 0);
                alu_reg   = 5'($urandom_range(0, 7));
                alu_data  = $urandom;
            end
            ReadRegister1 = 5'($urandom_range(0, 7));
            ReadRegister2 = 5'($urandom_range(0, 7));
            #1;
            w1 = byp_model(ReadRegister1);
            w2 = byp_model(ReadRegister2);
            vec++; if (mem_ready !== (mq.size() < DEPTH)) begin errs++; $display("FAIL rnd_mem_ready c%0d: got %0b want %0b", c, mem_ready, mq.size() < DEPTH); end
            vec++; if (alu_ready !== ((DEPTH - mq.size() >= 2) || (mq.size() < DEPTH && !mem_valid))) begin errs++; $display("FAIL rnd_alu_ready c%0d: got %0b size=%0d", c, alu_ready, mq.size()); end
            vec++; if (count !== CW'(mq.size())) begin errs++; $display("FAIL rnd_count c%0d: got %0d want %0d", c, count, mq.size()); end
            vec++; if ({hit1, hit_data1} !== w1) begin errs++; $display("FAIL rnd_hit1 c%0d: got %0b/%0h want %0b/%0h", c, hit1, hit_data1, w1[N], w1[N-1:0]); end
            vec++; if ({hit2, hit_data2} !== w2) begin errs++; $display("FAIL rnd_hit2 c%0d: got %0b/%0h want %0b/%0h", c, hit2, hit_data2, w2[N], w2[N-1:0]); end
            tick();
            vec++; if ({RegWrite, WriteRegister, WriteData} !== {exp_rw, exp_wr, exp_wd}) begin errs++; $display("FAIL rnd_write c%0d: got %0b/%0d/%0h want %0b/%0d/%0h", c, RegWrite, WriteRegister, WriteData, exp_rw, exp_wr, exp_wd); end
        end
    endtask

    task automatic test_reset_mid();
        mem_valid = 1'b1; mem_reg = 5'd9;  mem_data = 32'h99;
        alu_valid = 1'b1; alu_reg = 5'd10; alu_data = 32'h1010;
        ReadRegister1 = 5'd9;
        tick();
        tick();
        rst = 1'b0;
        #1;
        vec++; if ({count, RegWrite} !== {CW'(0), 1'b0}) begin errs++; $display("FAIL mid_reset: got count=%0d rw=%0b want 0 0", count, RegWrite); end
`ifdef WQ_BYPASS_EN
        vec++; if (hit1 !== 1'b0) begin errs++; $display("FAIL mid_reset_hit: got %0b want 0", hit1); end
`endif
        model_reset();
        @(posedge clk);
        #1;
        idle_inputs();
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            vec++; if ({RegWrite, count} !== {1'b0, CW'(0)}) begin errs++; $display("FAIL mid_after c%0d: got rw=%0b count=%0d want 0 0", c, RegWrite, count); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_dual();
        test_backpressure();
        test_reg0();
        test_bypass();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule

// File: doc/regfile_write_queue.md
Name: regfile_write_queue

Overview:
- Writer-side front end for the 32x32 register file.
- Accepts writeback requests from two producers, the ALU stage and the memory-load stage, each with a valid/ready handshake.
- Buffers the requests in a small in-order FIFO and drains one entry per cycle onto the register file's single write port (RegWrite / WriteRegister / WriteData).
- Optionally exposes pending-write bypass lookups for the two read addresses.

Parameters:
- N, 32, data width of a register.
- DEPTH, 4, FIFO entries (power of two, >= 2).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- alu_valid  input  1  ALU writeback request.
- alu_reg  input  5  ALU destination register.
- alu_data  input  N  ALU result.
- alu_ready  output  1  ALU request may be accepted this cycle.
- mem_valid  input  1  load writeback request.
- mem_reg  input  5  load destination register.
- mem_data  input  N  load data.
- mem_ready  output  1  load request may be accepted this cycle.
- RegWrite  output  1  write enable to register file.
- WriteRegister  output  5  write address to register file.
- WriteData  output  N  write data to register file.
- count  output  $clog2(DEPTH)+1  occupied FIFO entries.
- ReadRegister1  input  5  bypass lookup address 1.
- ReadRegister2  input  5  bypass lookup address 2.
- hit1  output  1  pending write to ReadRegister1 exists.
- hit2  output  1  pending write to ReadRegister2 exists.
- hit_data1  output  N  youngest pending data for ReadRegister1.
- hit_data2  output  N  youngest pending data for ReadRegister2.

Behaviour:
- Reset (rst=0, async): count=0, head/tail pointers=0, RegWrite=0, WriteRegister=0, WriteData=0, hit1=hit2=0, hit_data1=hit_data2=0.
- Reset mid-operation: all pending entries are discarded; nothing further is written.
- Free slots: free = DEPTH - count, sampled before this cycle's pop (conservative).
- mem_ready = (free >= 1).
- alu_ready = (free >= 2) || (free >= 1 && !mem_valid).
- Neither ready depends on its own valid; both are combinational from count and mem_valid.
- Accept: handshake is valid && ready at the rising edge. A valid without ready has no effect; the producer must hold its request.
- Simultaneous accept: the mem entry is enqueued first (older instruction), then the alu entry; tail advances by 2.
- Register 0: a request with reg==0 completes the handshake but is not enqueued. It never reaches the write port and never produces a bypass hit.
- Drain: each cycle with count>0, the head entry is popped. On that edge the output registers load RegWrite=1, WriteRegister=head.reg, WriteData=head.data. When count==0, RegWrite loads 0 and the address/data registers hold their values.
- Latency: a request accepted at edge k into an empty queue pops at edge k+1. RegWrite is high from k+1 to k+2, and the register file captures the write at edge k+2.
- Throughput: one write per cycle, sustained.
- Same-cycle push and pop: allowed; count' = count + pushes - pop. count never exceeds DEPTH.
- Pointers wrap modulo DEPTH.
- Ordering: writes leave the queue strictly in acceptance order. Two writes to the same register reach the file in order.

Optional Feature:
- Macro WQ_BYPASS_EN.
- Defined:
  - hitX = 1 when ReadRegisterX != 0 and it matches either a valid FIFO entry or the output stage (RegWrite==1 && WriteRegister==ReadRegisterX).
  - hit_dataX = data of the youngest match. Priority: youngest FIFO entry, then older entries, then the output stage.
  - Both outputs are combinational.
- Undefined: hit1, hit2, hit_data1 and hit_data2 are tied to 0 and no comparators are built. The ports remain present.

Test Plan:
- Reset then idle: rst low, then high, no valids -> RegWrite=0, count=0, alu_ready=mem_ready=1.
- Single write: alu_valid, reg=5, data=0xDEADBEEF accepted at edge 1 -> RegWrite=1, WriteRegister=5, WriteData=0xDEADBEEF after edge 2; RegWrite=0 after edge 3.
- Dual write: mem (reg=3, data=0x11) and alu (reg=3, data=0x22) in the same cycle -> two consecutive writes, 0x11 then 0x22; final register value 0x22.
- Fill and backpressure (DEPTH=4): two dual-accept cycles -> first pop leaves count=3; with count=3 and mem_valid=1, alu_ready=0 and mem_ready=1; at count=4 both readies are 0; alu requests held until space frees; no entry lost or duplicated.
- Register 0: alu_valid, reg=0, data=0xFFFFFFFF -> handshake completes, count stays 0, no RegWrite pulse, hit1=0 with ReadRegister1=0.
- Bypass (WQ_BYPASS_EN): queue holds reg 7 = 0xA, then reg 7 = 0xB; ReadRegister1=7 -> hit1=1, hit_data1=0xB; after both drain -> hit1=0. Without the macro, hit1 stays 0 throughout.
